// File: rtl/riscv_data_memory_if.sv
// riscv_data_memory_if
// MEM-stage data memory bus between the pipeline and riscv_data_memory.
//   addr        : byte address (EX/MEM ALU result)
//   write_data  : lane-aligned store data, byte i in bits [8i+7:8i]
//   write_en    : store request this cycle
//   read_en     : load request this cycle
//   byte_enable : store lane mask, bit i enables byte lane i
//   read_data   : raw 32-bit word returned combinationally
// master = CPU side, slave = memory side.
interface riscv_data_memory_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        write_en;
    logic        read_en;
    logic [3:0]  byte_enable;
    logic [31:0] read_data;

    modport master (
        output addr, write_data, write_en, read_en, byte_enable,
        input  read_data
    );

    modport slave (
        input  addr, write_data, write_en, read_en, byte_enable,
        output read_data
    );
endinterface

// File: rtl/riscv_data_memory.sv
// riscv_data_memory
// Byte-addressable, word-organised data memory for the RV32I MEM stage.
// Loads are combinational (latency 0); stores commit on the rising edge
// under per-byte lane enables. Raw words only: alignment and extension
// are done by the CPU.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, clears every word
//   bus : riscv_data_memory_if.slave (addr/write_data/write_en/read_en/
//         byte_enable in, read_data out)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words, power of two
//   BASE_ADDR   : byte address of word 0
module riscv_data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_data_memory_if.slave    bus
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Span in bytes, kept 33 bits wide so a 4 GiB span cannot overflow.
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [3:0][7:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned
    // compare covers both bounds.
    assign offset   = bus.addr - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN);
    // addr[1:0] never selects anything; lanes come from byte_enable only.
    assign idx      = offset[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < DEPTH_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (bus.write_en && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byte_enable[b]) begin
                    mem[idx][b] <= bus.write_data[8*b +: 8];
                end
            end
        end
    end

    // No write bypass: a same-cycle store is visible only after the edge.
    always_comb begin
        bus.read_data = 32'h0;
        if (bus.read_en && in_range) begin
            bus.read_data = mem[idx];
        end
    end

endmodule

// File: tb/tb_riscv_data_memory.sv
// tb_riscv_data_memory
// Directed self-checking bench for riscv_data_memory (default parameters:
// 1024 words at base 0). Inputs change 1 time unit after each rising edge;
// combinational reads are checked after a further settle delay.
module tb_riscv_data_memory;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    riscv_data_memory_if bus ();

    riscv_data_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic re, input logic [3:0] be);
        bus.addr        = a;
        bus.write_data  = wd;
        bus.write_en    = we;
        bus.read_en     = re;
        bus.byte_enable = be;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store one word and let it commit on the next edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be);
        drive(a, wd, 1'b1, 1'b0, be);
        tick();
        drive(a, 32'h0, 1'b0, 1'b0, 4'h0);
    endtask

    // Combinational load check; no edge is consumed.
    task automatic rd(input string tag, input logic [31:0] a,
                      input logic re, input logic [31:0] exp);
        drive(a, 32'h0, 1'b0, re, 4'h0);
        #1;
        check(tag, bus.read_data, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        rd("reset_word10", 32'h10, 1'b1, 32'h0);
        rd("reset_word0",  32'h00, 1'b1, 32'h0);

        // Reset clears written data
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd("pre_reset_10", 32'h10, 1'b1, 32'hDEADBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd("post_reset_10", 32'h10, 1'b1, 32'h0);

        // Full-word store/load, read_en gating
        wr(32'h04, 32'h12345678, 4'hF);
        rd("full_word_04", 32'h04, 1'b1, 32'h12345678);
        rd("read_en_low",  32'h04, 1'b0, 32'h0);

        // Byte / half lanes
        wr(32'h08, 32'h11223344, 4'hF);
        rd("lane_init_08", 32'h08, 1'b1, 32'h11223344);
        wr(32'h08, 32'h0000AA00, 4'b0010);
        rd("lane_byte1", 32'h08, 1'b1, 32'h1122AA44);
        wr(32'h08, 32'hBBCC0000, 4'b1100);
        rd("lane_upper_half", 32'h08, 1'b1, 32'hBBCCAA44);

        // Misaligned address indexes its word; zero mask is a no-op
        wr(32'h0E, 32'hCAFEF00D, 4'hF);
        rd("misaligned_0C", 32'h0C, 1'b1, 32'hCAFEF00D);
        rd("misaligned_0F", 32'h0F, 1'b1, 32'hCAFEF00D);
        wr(32'h0C, 32'hFFFFFFFF, 4'h0);
        rd("zero_mask", 32'h0C, 1'b1, 32'hCAFEF00D);

        // Out of range
        wr(32'h1000, 32'h55555555, 4'hF);
        rd("oor_read_1000", 32'h1000, 1'b1, 32'h0);
        rd("oor_keep_00",   32'h00,   1'b1, 32'h0);
        rd("oor_keep_04",   32'h04,   1'b1, 32'h12345678);
        rd("oor_keep_0C",   32'h0C,   1'b1, 32'hCAFEF00D);
        wr(32'h0FFC, 32'hA5A5A5A5, 4'hF);
        rd("last_word",     32'h0FFC, 1'b1, 32'hA5A5A5A5);
        rd("last_no_alias", 32'h00,   1'b1, 32'h0);
        rd("oor_top",       32'hFFFFFFFC, 1'b1, 32'h0);

        // Same-cycle read and write: old data before the edge, new after
        wr(32'h20, 32'h1, 4'hF);
        drive(32'h20, 32'h2, 1'b1, 1'b1, 4'hF);
        #1;
        check("rw_pre_edge", bus.read_data, 32'h1);
        tick();
        check("rw_post_edge", bus.read_data, 32'h2);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0);

        // Reset wins over a simultaneous store and clears everything
        drive(32'h20, 32'h77, 1'b1, 1'b0, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
        rd("rst_store_20", 32'h20,   1'b1, 32'h0);
        rd("rst_clear_04", 32'h04,   1'b1, 32'h0);
        rd("rst_clear_FFC", 32'h0FFC, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
